// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with a two-entry skid buffer.
// Carries one opaque WIDTH-bit bundle between two stages over a valid/ready handshake.
// in_ready is a function of registered state and flush only, so it never depends on out_ready.
// Synchronous flush squashes held entries. A saturating counter records back-pressure cycles.
module pipe_stage_elastic #(
  parameter int unsigned      WIDTH          = 64,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter bit               CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned      CNTW           = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [1:0]       occupancy,
  output logic [CNTW-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  main_q, main_d;
  logic [WIDTH-1:0]  skid_q, skid_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              acc, pop;

  // Handshake decode; the unused encoding 3 behaves exactly like StEmpty.
  always_comb begin
    out_valid = (state_q == StOne) || (state_q == StFull);
    occupancy = out_valid ? state_q : 2'd0;
    in_ready  = (state_q != StFull) && !flush;
    acc       = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = main_q;
    stall_cnt = cnt_q;
  end

  // Next-state and data-register load selection; flush overrides every other event.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      if (CLEAR_ON_FLUSH) begin
        main_d = RESET_VAL;
        skid_d = RESET_VAL;
      end
    end else begin
      case (state_q)
        StOne: begin
          if (acc && pop) begin
            main_d = in_data;
          end else if (acc) begin
            skid_d  = in_data;
            state_d = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // Skid entry is older than nothing but younger than main; it only ever moves to main.
          if (pop) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
          if (acc) begin
            main_d  = in_data;
            state_d = StOne;
          end
        end
      endcase
    end
  end

  // Stall counter next value: clear beats increment, increment saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (out_valid && !out_ready && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, data and counter registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StEmpty;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed vector table plus hand sequences and a queue-model stress run for pipe_stage_elastic.
module tb_pipe_stage_elastic;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNTW  = 2;
  localparam logic [7:0]  RVAL  = 8'hE7;

  logic            clk = 1'b0;
  logic            nrst;
  logic            in_valid, in_ready, out_valid, out_ready, flush, clr_cnt;
  logic [7:0]      in_data, out_data;
  logic [1:0]      occupancy;
  logic [CNTW-1:0] stall_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  pipe_stage_elastic #(
    .WIDTH(WIDTH),
    .RESET_VAL(RVAL),
    .CLEAR_ON_FLUSH(1'b1),
    .CNTW(CNTW)
  ) dut (
    .CLK(clk),
    .nRST(nrst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .flush(flush),
    .clr_cnt(clr_cnt),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       clr;
    logic       e_rdy;  // in_ready just before the edge, with these inputs applied
    logic       e_ov;   // registered outputs just after the edge
    logic [7:0] e_od;
    logic [1:0] e_occ;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                       input logic clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = clr;
  endtask

  logic [7:0] q[$];
  logic [1:0] mcnt;
  logic       m_rdy, m_acc, m_pop, r_iv, r_or, r_fl, r_clr;
  logic [7:0] r_d;

  initial begin
    //             iv  d      or   fl   clr  rdy  ov   od     occ  cnt
    // streaming
    vecs.push_back('{1, 8'h11, 1, 0, 0, 1, 1, 8'h11, 2'd1, 2'd0});
    vecs.push_back('{1, 8'h22, 1, 0, 0, 1, 1, 8'h22, 2'd1, 2'd0});
    vecs.push_back('{1, 8'h33, 1, 0, 0, 1, 1, 8'h33, 2'd1, 2'd0});
    vecs.push_back('{0, 8'h00, 1, 0, 0, 1, 0, 8'h33, 2'd0, 2'd0});
    // back-pressure into the skid slot, rejected offer, then drain in order
    vecs.push_back('{1, 8'hA1, 0, 0, 0, 1, 1, 8'hA1, 2'd1, 2'd0});
    vecs.push_back('{1, 8'hB2, 0, 0, 0, 1, 1, 8'hA1, 2'd2, 2'd1});
    vecs.push_back('{1, 8'hC3, 0, 0, 0, 0, 1, 8'hA1, 2'd2, 2'd2});
    vecs.push_back('{1, 8'hC3, 1, 0, 0, 0, 1, 8'hB2, 2'd1, 2'd2});
    vecs.push_back('{0, 8'h00, 1, 0, 0, 1, 0, 8'hB2, 2'd0, 2'd2});
    vecs.push_back('{0, 8'h00, 0, 0, 1, 1, 0, 8'hB2, 2'd0, 2'd0});
    // flush from FULL with an offer on the flush cycle
    vecs.push_back('{1, 8'h5A, 0, 0, 0, 1, 1, 8'h5A, 2'd1, 2'd0});
    vecs.push_back('{1, 8'h6B, 0, 0, 0, 1, 1, 8'h5A, 2'd2, 2'd1});
    vecs.push_back('{1, 8'h7C, 0, 1, 0, 0, 0, RVAL,  2'd0, 2'd2});
    vecs.push_back('{1, 8'h7C, 1, 0, 0, 1, 1, 8'h7C, 2'd1, 2'd2});
    vecs.push_back('{0, 8'h00, 1, 0, 1, 1, 0, 8'h7C, 2'd0, 2'd0});
    // stall counter saturation and clear-with-stall
    vecs.push_back('{1, 8'h99, 0, 0, 0, 1, 1, 8'h99, 2'd1, 2'd0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 1, 1, 8'h99, 2'd1, 2'd1});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 1, 1, 8'h99, 2'd1, 2'd2});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 1, 1, 8'h99, 2'd1, 2'd3});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 1, 1, 8'h99, 2'd1, 2'd3});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 1, 1, 8'h99, 2'd1, 2'd3});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 1, 1, 8'h99, 2'd1, 2'd3});
    vecs.push_back('{0, 8'h00, 0, 0, 1, 1, 1, 8'h99, 2'd1, 2'd0});
    vecs.push_back('{0, 8'h00, 1, 0, 0, 1, 0, 8'h99, 2'd0, 2'd0});

    nrst = 1'b0;
    drive(0, 8'h00, 0, 0, 0);
    #12;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset occupancy", 32'(occupancy), 0);
    check("reset out_data", 32'(out_data), 32'(RVAL));
    check("reset in_ready", 32'(in_ready), 1);
    check("reset stall_cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    nrst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      check($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
      check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_cnt));
    end

    // Asynchronous reset while FULL, then a single push after release.
    @(negedge clk); drive(1, 8'h31, 0, 0, 0);
    @(negedge clk); drive(1, 8'h32, 0, 0, 0);
    @(negedge clk); drive(0, 8'h00, 0, 0, 0);
    #1;
    check("pre-reset occupancy", 32'(occupancy), 2);
    check("pre-reset stall_cnt", 32'(stall_cnt), 1);
    #1 nrst = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 0);
    check("async occupancy", 32'(occupancy), 0);
    check("async stall_cnt", 32'(stall_cnt), 0);
    check("async out_data", 32'(out_data), 32'(RVAL));
    @(negedge clk);
    nrst = 1'b1;
    drive(1, 8'h42, 1, 0, 0);
    @(posedge clk); #1;
    check("post-reset out_valid", 32'(out_valid), 1);
    check("post-reset out_data", 32'(out_data), 32'h42);
    @(negedge clk); drive(0, 8'h00, 1, 0, 1);
    @(posedge clk); #1;
    check("post-reset drained", 32'(out_valid), 0);

    // Random stress against a FIFO model of depth two.
    mcnt = 2'd0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      r_iv  = ($urandom_range(0, 3) != 0);
      r_d   = 8'($urandom_range(0, 255));
      r_or  = ($urandom_range(0, 2) != 0);
      r_fl  = ($urandom_range(0, 31) == 0);
      r_clr = ($urandom_range(0, 63) == 0);
      drive(r_iv, r_d, r_or, r_fl, r_clr);
      #1;
      m_rdy = (q.size() < 2) && !r_fl;
      m_acc = r_iv && m_rdy;
      m_pop = (q.size() != 0) && r_or;
      check("rnd in_ready", 32'(in_ready), 32'(m_rdy));
      check("rnd out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) check("rnd out_data", 32'(out_data), 32'(q[0]));
      if (r_clr) mcnt = 2'd0;
      else if ((q.size() != 0) && !r_or && (mcnt != 2'd3)) mcnt = mcnt + 2'd1;
      if (r_fl) begin
        q.delete();
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_acc) q.push_back(r_d);
      end
      @(posedge clk); #1;
      check("rnd occupancy", 32'(occupancy), 32'(q.size()));
      check("rnd stall_cnt", 32'(stall_cnt), 32'(mcnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
